controle_rolhas: RTL and testbench

Supervisory controller that sequences the bottling line around the fill/seal production FSM. It owns the cork supply: a dispenser stock feeds the sealer, and an internal reserve refills it in batches. It drives the production FSM's RO input and the line-enable `run` gate, counts produced bottles into dozens, and raises an alarm when corks run out. It sits between the operator panel (start/stop/reload) and the production FSM (GP in, RO/run out).

---
 rtl/controle_rolhas.sv | 153 +++++++++++++++
 tb/tb_controle_rolhas.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/controle_rolhas.sv
// Supervisory controller for the bottling line: cork dispenser/reserve bookkeeping,
// refill sequencing, line enable, cork-out alarm and bottle/dozen counting.
module controle_rolhas #(
    parameter int ESTOQUE_MAX     = 99,
    parameter int RESERVA_MAX     = 99,
    parameter int RESERVA_INICIAL = 99,
    parameter int LIMIAR          = 5,
    parameter int LOTE_RECARGA    = 15,
    parameter int LOTE_OPERADOR   = 20,
    parameter int DUZIAS_MAX      = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       GP,
    input  logic       add_reserva,
    output logic       run,
    output logic       RO,
    output logic       recarga,
    output logic       AL,
    output logic       DZ,
    output logic [6:0] estoque,
    output logic [6:0] reserva,
    output logic [3:0] garrafas,
    output logic [6:0] duzias,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        PARADO     = 2'd0,
        PRODUZINDO = 2'd1,
        RECARGA    = 2'd2,
        ALARME     = 2'd3
    } estado_t;

    localparam logic [6:0] E_MAX  = 7'(ESTOQUE_MAX);
    localparam logic [7:0] R_MAX  = 8'(RESERVA_MAX);
    localparam logic [6:0] R_INI  = 7'(RESERVA_INICIAL);
    localparam logic [6:0] LIM    = 7'(LIMIAR);
    localparam logic [6:0] LOTE   = 7'(LOTE_RECARGA);
    localparam logic [7:0] L_OPER = 8'(LOTE_OPERADOR);
    localparam logic [6:0] D_MAX  = 7'(DUZIAS_MAX);

    estado_t    estado, estado_next;
    logic [6:0] lote, lote_next, lote_inc;
    logic       stop_latch, latch_next;
    logic       transfer;
    logic [6:0] estoque_next, reserva_next;
    logic [7:0] soma;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        transfer     = (estado == RECARGA) && (reserva != 7'd0) && (estoque != E_MAX);
        estoque_next = estoque;
        if (transfer && !GP)
            estoque_next = estoque + 7'd1;
        else if (!transfer && GP && estoque != 7'd0)
            estoque_next = estoque - 7'd1;

        // Widened to 8 bits so an operator load cannot wrap before saturation.
        soma         = {1'b0, reserva} + (add_reserva ? L_OPER : 8'd0) - {7'd0, transfer};
        reserva_next = (soma > R_MAX) ? R_MAX[6:0] : soma[6:0];

        estado_next = estado;
        lote_next   = lote;
        latch_next  = stop_latch;
        lote_inc    = lote + 7'd1;

        case (estado)
            PARADO: begin
                if (start && !stop) begin
                    if (estoque > LIM)
                        estado_next = PRODUZINDO;
                    else if (reserva != 7'd0)
                        estado_next = RECARGA;
                    else
                        estado_next = ALARME;
                end
            end
            PRODUZINDO: begin
                if (stop)
                    estado_next = PARADO;
                else if (estoque_next <= LIM && reserva_next != 7'd0)
                    estado_next = RECARGA;
                else if (estoque_next == 7'd0 && reserva_next == 7'd0)
                    estado_next = ALARME;
            end
            RECARGA: begin
                // A stop is only remembered here; the batch always runs to completion.
                if (stop)
                    latch_next = 1'b1;
                if (lote_inc == LOTE || reserva_next == 7'd0 || estoque_next == E_MAX) begin
                    lote_next = 7'd0;
                    if (stop_latch || stop) begin
                        estado_next = PARADO;
                        latch_next  = 1'b0;
                    end else if (estoque_next == 7'd0) begin
                        estado_next = ALARME;
                    end else begin
                        estado_next = PRODUZINDO;
                    end
                end else begin
                    lote_next = lote_inc;
                end
            end
            ALARME: begin
                if (stop)
                    estado_next = PARADO;
                else if (add_reserva)
                    estado_next = RECARGA;
            end
            default: estado_next = PARADO;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado     <= PARADO;
            estoque    <= 7'd0;
            reserva    <= R_INI;
            garrafas   <= 4'd0;
            duzias     <= 7'd0;
            DZ         <= 1'b0;
            stop_latch <= 1'b0;
            lote       <= 7'd0;
        end else begin
            estado     <= estado_next;
            estoque    <= estoque_next;
            reserva    <= reserva_next;
            stop_latch <= latch_next;
            lote       <= lote_next;
            DZ         <= 1'b0;
            if (GP) begin
                if (garrafas == 4'd11) begin
                    garrafas <= 4'd0;
                    DZ       <= 1'b1;
                    duzias   <= (duzias == D_MAX) ? 7'd0 : duzias + 7'd1;
                end else begin
                    garrafas <= garrafas + 4'd1;
                end
            end
        end
    end

    assign state   = estado;
    assign RO      = (estoque != 7'd0);
    assign recarga = (estado == RECARGA);
    assign AL      = (estado == ALARME);
    assign run     = (estado == PRODUZINDO) || ((estado == RECARGA) && (estoque != 7'd0));

endmodule

// File: tb/tb_controle_rolhas.sv
// Directed bench for controle_rolhas: refill sequencing, stop latch, alarm recovery,
// reserve saturation, asynchronous reset mid-batch and dozen counting.
module tb_controle_rolhas;

    logic       clk = 1'b0;
    logic       reset, start, stop, GP, add_reserva;
    logic       run, RO, recarga, AL, DZ;
    logic [6:0] estoque, reserva, duzias;
    logic [3:0] garrafas;
    logic [1:0] state;

    int n_checks = 0;
    int n_errors = 0;
    int dz_count = 0;

    controle_rolhas dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .GP(GP),
        .add_reserva(add_reserva), .run(run), .RO(RO), .recarga(recarga), .AL(AL),
        .DZ(DZ), .estoque(estoque), .reserva(reserva), .garrafas(garrafas),
        .duzias(duzias), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, state, 0);
        check({tag, "_estoque"}, estoque, 0);
        check({tag, "_reserva"}, reserva, 99);
        check({tag, "_garrafas"}, garrafas, 0);
        check({tag, "_duzias"}, duzias, 0);
        check({tag, "_outs"}, {run, RO, recarga, AL, DZ}, 5'b00000);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; GP = 1'b0; add_reserva = 1'b0;
        #13;
        check_reset_values("rst");
        reset = 1'b0;
        tick(1);
        check_reset_values("rst_rel");

        // First start with an empty dispenser goes straight into a refill.
        start = 1'b1; tick(1); start = 1'b0;
        check("start_state", state, 2);
        check("start_run", run, 0);
        tick(1);
        check("first_xfer_estoque", estoque, 1);
        check("first_xfer_run", run, 1);
        tick(14);
        check("batch1_estoque", estoque, 15);
        check("batch1_reserva", reserva, 84);
        check("batch1_state", state, 1);

        // Ten bottles bring the dispenser down to the threshold.
        GP = 1'b1; tick(10); GP = 1'b0;
        check("thr_estoque", estoque, 5);
        check("thr_state", state, 2);
        check("thr_garrafas", garrafas, 10);
        tick(15);
        check("batch2_estoque", estoque, 20);
        check("batch2_reserva", reserva, 69);
        check("batch2_state", state, 1);

        // Stop inside a refill: batch completes, then line parks.
        GP = 1'b1; tick(15); GP = 1'b0;
        check("b3_enter_state", state, 2);
        check("b3_duzias", duzias, 2);
        check("b3_garrafas", garrafas, 1);
        tick(3);
        stop = 1'b1; tick(1); stop = 1'b0;
        check("stop_in_refill_state", state, 2);
        tick(10);
        check("batch14_state", state, 2);
        tick(1);
        check("stop_exit_state", state, 0);
        check("stop_exit_run", run, 0);
        check("stop_exit_estoque", estoque, 20);
        check("stop_exit_reserva", reserva, 54);

        start = 1'b1; stop = 1'b1; tick(1);
        check("stop_wins_state", state, 0);
        stop = 1'b0; tick(1); start = 1'b0;
        check("restart_state", state, 1);

        // GP coinciding with a transfer leaves the dispenser unchanged.
        GP = 1'b1; tick(15); GP = 1'b0;
        check("b4_enter_estoque", estoque, 5);
        GP = 1'b1; tick(1); GP = 1'b0;
        check("gp_xfer_estoque", estoque, 5);
        check("gp_xfer_reserva", reserva, 53);
        tick(14);
        check("b4_estoque", estoque, 19);
        check("b4_reserva", reserva, 39);
        check("b4_state", state, 1);

        // Continuous production drains the reserve down to empty.
        GP = 1'b1; tick(57); GP = 1'b0;
        check("drain_estoque", estoque, 1);
        check("drain_reserva", reserva, 0);
        check("drain_state", state, 1);
        GP = 1'b1; tick(1); GP = 1'b0;
        check("alarm_estoque", estoque, 0);
        check("alarm_state", state, 3);
        check("alarm_AL", AL, 1);
        check("alarm_RO", RO, 0);
        check("alarm_run", run, 0);

        add_reserva = 1'b1; tick(1); add_reserva = 1'b0;
        check("recover_reserva", reserva, 20);
        check("recover_state", state, 2);
        tick(15);
        check("recover_estoque", estoque, 15);
        check("recover_reserva_end", reserva, 5);
        check("recover_state_end", state, 1);

        // Operator loads, the last one saturating at capacity.
        add_reserva = 1'b1; tick(4); add_reserva = 1'b0;
        check("load_reserva", reserva, 85);
        add_reserva = 1'b1; tick(1); add_reserva = 1'b0;
        check("load_sat_reserva", reserva, 99);
        check("load_state", state, 1);

        // Asynchronous reset in the middle of a refill batch.
        GP = 1'b1; tick(10); GP = 1'b0;
        check("b5_state", state, 2);
        tick(3);
        check("b5_mid_estoque", estoque, 8);
        check("b5_mid_reserva", reserva, 96);
        #3 reset = 1'b1;
        #1;
        check_reset_values("rst_mid");
        #2 reset = 1'b0;
        tick(1);

        // Dozen counting is independent of cork availability.
        GP = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            tick(1);
            if (DZ) dz_count++;
            if (i == 11) check("garrafas_11", garrafas, 11);
            if (i == 12) check("dz_first", DZ, 1);
            if (i == 13) check("dz_one_cycle", DZ, 0);
        end
        GP = 1'b0;
        tick(1);
        check("dz_count", dz_count, 2);
        check("duzias_2", duzias, 2);
        check("garrafas_0", garrafas, 0);
        check("dz_state", state, 0);
        GP = 1'b1; tick(97 * 12); GP = 1'b0;
        check("duzias_max", duzias, 99);
        GP = 1'b1; tick(12); GP = 1'b0;
        check("duzias_wrap", duzias, 0);
        check("dz_wrap", DZ, 1);
        check("garrafas_wrap", garrafas, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
